trace_event_encoder: RTL and testbench

TRACE_EVENT_ENCODER -- requirements
Module: trace_event_encoder

---
 rtl/trace_event_pkg.sv | 15 +
 rtl/trace_event_fifo.sv | 38 +++
 rtl/trace_event_encoder.sv | 85 ++++++++
 tb/tb_trace_event_encoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/trace_event_pkg.sv
// trace_event_pkg: l.nop trace decode constants, type codes, serializer states and event record
package trace_event_pkg;
  localparam logic [7:0] NOP_OPC = 8'h15;
  localparam logic [15:0] K_EXIT = 16'h0001;
  localparam logic [15:0] K_REPORT = 16'h0002;
  localparam logic [15:0] K_PUTC = 16'h0004;
  localparam logic [1:0] T_EXIT = 2'b01;
  localparam logic [1:0] T_PUTC = 2'b10;
  localparam logic [1:0] T_REPORT = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HI, S_LO, S_DONE} state_e;
  typedef struct packed {
    logic [1:0] typ;
    logic [31:0] val;
  } event_t;
endpackage

// File: rtl/trace_event_fifo.sv
// trace_event_fifo: FIFO of 34-bit {type,value} trace events.
// Ports: clk, rst_n (async active-low), push_i/din_i write side,
// pop_i/dout_o read side (dout_o is the current head), count_o occupancy.
// The caller guarantees push_i only when not full or popping, and pop_i only when not empty.
module trace_event_fifo
  import trace_event_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [33:0]                   din_i,
  input  logic                          pop_i,
  output logic [33:0]                   dout_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  event_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/trace_event_encoder.sv
// trace_event_encoder: turns l.nop trace events at writeback into 3-flit packets.
// Ports: clk, rst_n (async active-low); enable/wb_pc/wb_insn/r3 writeback snoop;
// out_valid/out_ready/out_data/out_last flit stream; terminated sticky after EXIT packet.
module trace_event_encoder
  import trace_event_pkg::*;
#(
  parameter int ID = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_insn,
  input  logic [31:0] r3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        terminated
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  event_t hold_q, hold_d, head;
  logic ovf_q, ovf_d, stop_q, stop_d, last_q, last_d;
  logic [15:0] data_q, data_d, k;
  logic [CW-1:0] count;
  logic [1:0] typ;
  logic hit, cap, pop, push, drop, adv;
  logic unused_ok;
  assign unused_ok = ^{wb_pc, wb_insn[23:16]};
  assign k = wb_insn[15:0];
  assign hit = enable && wb_insn[31:24] == NOP_OPC && (k == K_EXIT || k == K_PUTC || k == K_REPORT);
  assign typ = k == K_EXIT ? T_EXIT : k == K_PUTC ? T_PUTC : T_REPORT;
  assign cap = hit && !stop_q;
  assign pop = state_q == S_IDLE && count != '0;
  // a full FIFO still accepts the event when the head leaves in the same cycle
  assign push = cap && (count != CW'(FIFO_DEPTH) || pop);
  assign drop = cap && !push;
  assign out_valid = state_q inside {S_HDR, S_HI, S_LO};
  assign adv = out_valid && out_ready;
  trace_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(push),
    .din_i({typ, r3}),
    .pop_i(pop),
    .dout_o(head),
    .count_o(count)
  );
  assign state_d = state_q == S_IDLE ? (pop ? S_HDR : S_IDLE)
                 : (state_q == S_DONE || !adv) ? state_q
                 : state_q == S_HDR ? S_HI
                 : state_q == S_HI ? S_LO
                 : hold_q.typ == T_EXIT ? S_DONE : S_IDLE;
  assign hold_d = pop ? head : hold_q;
  // a drop coinciding with the header handshake must survive into the next header
  assign ovf_d = drop || (ovf_q && !(state_q == S_HDR && adv));
  assign stop_d = stop_q || (push && typ == T_EXIT);
  // flits are registered; the header (with its ovf bit) is frozen when built so it stays stable under stall
  assign data_d = state_d == S_HDR ? (pop ? {head.typ, ovf_d, 5'b0, 8'(ID)} : data_q)
                : state_d == S_HI ? hold_q.val[31:16]
                : state_d == S_LO ? hold_q.val[15:0] : '0;
  assign last_d = state_d == S_LO;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      ovf_q <= 1'b0;
      stop_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      ovf_q <= ovf_d;
      stop_q <= stop_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end
  assign out_data = data_q;
  assign out_last = last_q;
  assign terminated = state_q == S_DONE;
endmodule

// File: tb/tb_trace_event_encoder.sv
// tb_trace_event_encoder: directed vector table plus hand-written multi-cycle sequences
module tb_trace_event_encoder;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic [31:0] wb_pc = '0, wb_insn = '0, r3 = '0;
  logic out_valid, out_last, terminated;
  logic [15:0] out_data;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  trace_event_encoder #(.ID(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wb_pc(wb_pc), .wb_insn(wb_insn), .r3(r3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .terminated(terminated)
  );
  typedef struct {
    logic en;
    logic [31:0] insn;
    logic [31:0] val;
    logic pkt;
    logic [15:0] hdr, hi, lo;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_event(input logic en, input logic [31:0] insn, input logic [31:0] val);
    @(posedge clk);
    #1 enable = en; wb_insn = insn; r3 = val; wb_pc = wb_pc + 32'd4;
    @(posedge clk);
    #1 enable = 1'b0; wb_insn = '0; r3 = '0;
  endtask
  task automatic get_flit(input string name, output logic [15:0] d, output logic l);
    bit got = 1'b0;
    d = '0;
    l = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1;
        d = out_data;
        l = out_last;
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: got no flit within 40 cycles, expected one", name);
    end
  endtask
  task automatic get_pkt(input string name, input logic [15:0] hdr, input logic [15:0] hi, input logic [15:0] lo);
    logic [15:0] d;
    logic l;
    get_flit({name, "_hdr"}, d, l);
    chk({name, "_hdr"}, {l, d}, {1'b0, hdr});
    get_flit({name, "_hi"}, d, l);
    chk({name, "_hi"}, {l, d}, {1'b0, hi});
    get_flit({name, "_lo"}, d, l);
    chk({name, "_lo"}, {l, d}, {1'b1, lo});
  endtask
  task automatic watch_idle(input string name, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk(name, seen, 1'b0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] d;
    logic l;
    vecs[0] = '{1'b1, 32'h15000004, 32'h00000041, 1'b1, 16'h8005, 16'h0000, 16'h0041};
    vecs[1] = '{1'b1, 32'h15000002, 32'hDEADBEEF, 1'b1, 16'hC005, 16'hDEAD, 16'hBEEF};
    vecs[2] = '{1'b1, 32'h15FF0004, 32'hCAFE0000, 1'b1, 16'h8005, 16'hCAFE, 16'h0000};
    vecs[3] = '{1'b0, 32'h15000004, 32'h00000001, 1'b0, 16'h0, 16'h0, 16'h0};
    vecs[4] = '{1'b1, 32'h15000003, 32'h00000001, 1'b0, 16'h0, 16'h0, 16'h0};
    vecs[5] = '{1'b1, 32'h14000004, 32'h00000001, 1'b0, 16'h0, 16'h0, 16'h0};
    vecs[6] = '{1'b1, 32'h15010002, 32'hFFFFFFFF, 1'b1, 16'hC005, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{1'b1, 32'h15000000, 32'h00000001, 1'b0, 16'h0, 16'h0, 16'h0};
    #2;
    chk("reset_outputs", {out_valid, out_last, out_data, terminated}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    send_event(1'b1, 32'h15000004, 32'h41);
    @(negedge clk);
    chk("putc_n1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("putc_hdr", {out_valid, out_last, out_data}, {2'b10, 16'h8005});
    @(negedge clk);
    chk("putc_hi", {out_valid, out_last, out_data}, {2'b10, 16'h0000});
    @(negedge clk);
    chk("putc_lo", {out_valid, out_last, out_data}, {2'b11, 16'h0041});
    @(negedge clk);
    chk("putc_after", out_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_event(vecs[i].en, vecs[i].insn, vecs[i].val);
      if (vecs[i].pkt) get_pkt($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].hi, vecs[i].lo);
      else watch_idle($sformatf("vec%0d_idle", i), 8);
    end
    send_event(1'b1, 32'h15000002, 32'h12345678);
    get_flit("bp_hdr", d, l);
    chk("bp_hdr", {l, d}, {1'b0, 16'hC005});
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {out_valid, out_last, out_data}, {2'b10, 16'h1234});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    get_flit("bp_hi", d, l);
    chk("bp_hi", {l, d}, {1'b0, 16'h1234});
    get_flit("bp_lo", d, l);
    chk("bp_lo", {l, d}, {1'b1, 16'h5678});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 enable = 1'b1; wb_insn = 32'h15000004; r3 = 32'(i + 1); out_ready = (i == 5);
    end
    @(negedge clk);
    chk("ovf_p1_hdr", {out_valid, out_data}, {1'b1, 16'h8005});
    @(posedge clk);
    #1 enable = 1'b0; wb_insn = '0; r3 = '0;
    get_flit("ovf_p1_hi", d, l);
    chk("ovf_p1_hi", {l, d}, {1'b0, 16'h0000});
    get_flit("ovf_p1_lo", d, l);
    chk("ovf_p1_lo", {l, d}, {1'b1, 16'h0001});
    get_pkt("ovf_p2", 16'hA005, 16'h0000, 16'h0002);
    get_pkt("ovf_p3", 16'h8005, 16'h0000, 16'h0003);
    get_pkt("ovf_p4", 16'h8005, 16'h0000, 16'h0004);
    get_pkt("ovf_p5", 16'h8005, 16'h0000, 16'h0005);
    watch_idle("ovf_p6_dropped", 10);
    send_event(1'b1, 32'h15000001, 32'h0);
    get_flit("exit_hdr", d, l);
    chk("exit_hdr", {l, d}, {1'b0, 16'h4005});
    get_flit("exit_hi", d, l);
    chk("exit_hi", {l, d}, {1'b0, 16'h0000});
    get_flit("exit_lo", d, l);
    chk("exit_lo", {l, d}, {1'b1, 16'h0000});
    chk("exit_term_pending", terminated, 1'b0);
    @(negedge clk);
    chk("exit_term", {terminated, out_valid}, 2'b10);
    send_event(1'b1, 32'h15000004, 32'h55);
    watch_idle("exit_later_putc", 10);
    chk("exit_term_sticky", terminated, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_clears_term", terminated, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_event(1'b1, 32'h15000004, 32'hABCD0123);
    get_flit("mid_hdr", d, l);
    chk("mid_hdr", {l, d}, {1'b0, 16'h8005});
    get_flit("mid_hi", d, l);
    chk("mid_hi", {l, d}, {1'b0, 16'hABCD});
    @(posedge clk);
    #1 out_ready = 1'b0;
    send_event(1'b1, 32'h15000002, 32'h99);
    @(negedge clk);
    chk("mid_lo_stall", {out_valid, out_last, out_data}, {2'b11, 16'h0123});
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_outputs", {out_valid, out_last, out_data, terminated}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    watch_idle("mid_rst_discard", 12);
    send_event(1'b1, 32'h15000004, 32'h7);
    get_pkt("post_rst", 16'h8005, 16'h0000, 16'h0007);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
